// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB pipeline register, load extract, writeback mux and retire counter
module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic [1:0]       mem_wb_sel,
  input  logic [2:0]       mem_funct3,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_pc_plus4,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic [4:0]       rf_write_addr,
  output logic [XLEN-1:0]  rf_write_data,
  output logic             rf_reg_write,
  output logic             wb_valid,
  output logic             wb_load_fault,
  output logic [CNT_W-1:0] instret
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic             wb_valid_q;
  logic             wb_reg_write_q;
  logic [4:0]       wb_rd_q;
  logic [1:0]       wb_sel_q;
  logic [2:0]       wb_funct3_q;
  logic [XLEN-1:0]  wb_alu_q;
  logic [XLEN-1:0]  wb_pc4_q;
  logic [CNT_W-1:0] instret_q;

  logic [1:0]       off;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [XLEN-1:0]  load_data;
  logic             misaligned;
  logic             illegal_f3;
  logic             fault;
  logic             write_en;

  // WB register: reset clears, flush inserts a bubble, stall holds, otherwise capture MEM
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_sel_q       <= 2'b00;
      wb_funct3_q    <= 3'b000;
      wb_alu_q       <= '0;
      wb_pc4_q       <= '0;
    end else if (flush) begin
      wb_valid_q     <= 1'b0;
    end else if (!stall) begin
      wb_valid_q     <= mem_valid;
      wb_reg_write_q <= mem_reg_write;
      wb_rd_q        <= mem_rd;
      wb_sel_q       <= mem_wb_sel;
      wb_funct3_q    <= mem_funct3;
      wb_alu_q       <= mem_alu_result;
      wb_pc4_q       <= mem_pc_plus4;
    end
  end

  // Count an instruction when it leaves WB; faulting loads still retire
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else if (wb_valid_q && !stall && !flush) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Pick the addressed byte/halfword out of the aligned memory word and extend it
  always_comb begin
    off     = wb_alu_q[1:0];
    ld_byte = 8'h00;
    case (off)
      2'd0: ld_byte = dmem_rdata[7:0];
      2'd1: ld_byte = dmem_rdata[15:8];
      2'd2: ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half   = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_data = '0;
    case (wb_funct3_q)
      F3_LB:   load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LBU:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LH:   load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_LHU:  load_data = {{(XLEN-16){1'b0}}, ld_half};
      F3_LW:   load_data = dmem_rdata;
      default: load_data = '0;
    endcase
  end

  // Fault detection applies only to load-sourced writebacks
  always_comb begin
    misaligned = (((wb_funct3_q == F3_LH) || (wb_funct3_q == F3_LHU)) && off[0]) ||
                 ((wb_funct3_q == F3_LW) && (off != 2'd0));
    illegal_f3 = (wb_funct3_q == 3'b011) || (wb_funct3_q == 3'b110) ||
                 (wb_funct3_q == 3'b111);
    fault      = (wb_sel_q == SEL_LOAD) && (misaligned || illegal_f3);
  end

  // Register-file write port: data is forced to zero whenever no write happens
  always_comb begin
    write_en = wb_valid_q && wb_reg_write_q && (wb_rd_q != 5'd0) && !fault &&
               (wb_sel_q != 2'b11);
    rf_write_data = '0;
    if (write_en) begin
      case (wb_sel_q)
        SEL_ALU:  rf_write_data = wb_alu_q;
        SEL_LOAD: rf_write_data = load_data;
        SEL_PC4:  rf_write_data = wb_pc4_q;
        default:  rf_write_data = '0;
      endcase
    end
  end

  assign rf_write_addr = wb_rd_q;
  assign rf_reg_write  = write_en;
  assign wb_valid      = wb_valid_q;
  assign wb_load_fault = wb_valid_q && fault;
  assign instret       = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed-vector bench for writeback_stage
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_pc_plus4;
  logic [31:0] dmem_rdata;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic        rf_reg_write;
  logic        wb_valid;
  logic        wb_load_fault;
  logic [63:0] instret;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_rd         (mem_rd),
    .mem_wb_sel     (mem_wb_sel),
    .mem_funct3     (mem_funct3),
    .mem_alu_result (mem_alu_result),
    .mem_pc_plus4   (mem_pc_plus4),
    .dmem_rdata     (dmem_rdata),
    .rf_write_addr  (rf_write_addr),
    .rf_write_data  (rf_write_data),
    .rf_reg_write   (rf_reg_write),
    .wb_valid       (wb_valid),
    .wb_load_fault  (wb_load_fault),
    .instret        (instret)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc4);
    mem_valid      = v;
    mem_reg_write  = rw;
    mem_rd         = rd;
    mem_wb_sel     = sel;
    mem_funct3     = f3;
    mem_alu_result = alu;
    mem_pc_plus4   = pc4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wb(input string tag, input logic [4:0] addr, input logic [31:0] data,
                        input logic we, input logic flt, input logic [63:0] ir);
    #1;
    chk({tag, ".we"},    64'(rf_reg_write), 64'(we));
    chk({tag, ".data"},  64'(rf_write_data), 64'(data));
    if (we) chk({tag, ".addr"}, 64'(rf_write_addr), 64'(addr));
    chk({tag, ".fault"}, 64'(wb_load_fault), 64'(flt));
    chk({tag, ".ir"},    instret, ir);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; dmem_rdata = 32'h0;
    issue(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0);

    // reset held two cycles with a valid instruction presented
    tick(); tick();
    #1;
    chk("rst.valid", 64'(wb_valid), 64'd0);
    chk("rst.we",    64'(rf_reg_write), 64'd0);
    chk("rst.data",  64'(rf_write_data), 64'd0);
    chk("rst.ir",    instret, 64'd0);
    rst = 1'b0;

    // ALU writeback
    issue(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 32'h1234_5678, 32'h0);
    tick();
    chk("alu.valid", 64'(wb_valid), 64'd1);
    chk_wb("alu", 5'd5, 32'h1234_5678, 1'b1, 1'b0, 64'd0);

    // loads against 80FF_7F01
    dmem_rdata = 32'h80FF_7F01;
    issue(1'b1, 1'b1, 5'd6, 2'b01, 3'b000, 32'h0000_2003, 32'h0);
    tick(); chk_wb("lb3",  5'd6, 32'hFFFF_FF80, 1'b1, 1'b0, 64'd1);
    issue(1'b1, 1'b1, 5'd6, 2'b01, 3'b100, 32'h0000_2003, 32'h0);
    tick(); chk_wb("lbu3", 5'd6, 32'h0000_0080, 1'b1, 1'b0, 64'd2);
    issue(1'b1, 1'b1, 5'd6, 2'b01, 3'b001, 32'h0000_2002, 32'h0);
    tick(); chk_wb("lh2",  5'd6, 32'hFFFF_80FF, 1'b1, 1'b0, 64'd3);
    issue(1'b1, 1'b1, 5'd6, 2'b01, 3'b101, 32'h0000_2002, 32'h0);
    tick(); chk_wb("lhu2", 5'd6, 32'h0000_80FF, 1'b1, 1'b0, 64'd4);
    issue(1'b1, 1'b1, 5'd6, 2'b01, 3'b010, 32'h0000_2000, 32'h0);
    tick(); chk_wb("lw0",  5'd6, 32'h80FF_7F01, 1'b1, 1'b0, 64'd5);
    issue(1'b1, 1'b1, 5'd6, 2'b01, 3'b000, 32'h0000_2001, 32'h0);
    tick(); chk_wb("lb1",  5'd6, 32'h0000_007F, 1'b1, 1'b0, 64'd6);
    issue(1'b1, 1'b1, 5'd6, 2'b01, 3'b001, 32'h0000_2000, 32'h0);
    tick(); chk_wb("lh0",  5'd6, 32'h0000_7F01, 1'b1, 1'b0, 64'd7);

    // faulting loads: write suppressed, still retire
    issue(1'b1, 1'b1, 5'd7, 2'b01, 3'b010, 32'h0000_1002, 32'h0);
    tick(); chk_wb("flw",  5'd7, 32'h0, 1'b0, 1'b1, 64'd8);
    issue(1'b1, 1'b1, 5'd7, 2'b01, 3'b001, 32'h0000_1001, 32'h0);
    tick(); chk_wb("flh",  5'd7, 32'h0, 1'b0, 1'b1, 64'd9);
    issue(1'b1, 1'b1, 5'd7, 2'b01, 3'b011, 32'h0000_1000, 32'h0);
    tick(); chk_wb("f011", 5'd7, 32'h0, 1'b0, 1'b1, 64'd10);
    // misaligned address on an ALU op is not a fault
    issue(1'b1, 1'b1, 5'd8, 2'b00, 3'b010, 32'h0000_1003, 32'h0);
    tick(); chk_wb("alumis", 5'd8, 32'h0000_1003, 1'b1, 1'b0, 64'd11);

    // rd=0, sel=11, PC+4
    issue(1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 32'h0000_0055, 32'h0);
    tick(); chk_wb("rd0",  5'd0, 32'h0, 1'b0, 1'b0, 64'd12);
    issue(1'b1, 1'b1, 5'd9, 2'b11, 3'b000, 32'h0000_0066, 32'h0000_0200);
    tick(); chk_wb("sel3", 5'd9, 32'h0, 1'b0, 1'b0, 64'd13);
    issue(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 32'h0000_0077, 32'h0000_0104);
    tick(); chk_wb("pc4",  5'd1, 32'h0000_0104, 1'b1, 1'b0, 64'd14);

    // stall for three edges: same write repeated, no counting
    issue(1'b1, 1'b1, 5'd10, 2'b00, 3'b000, 32'h0000_AAAA, 32'h0);
    tick(); chk_wb("st0", 5'd10, 32'h0000_AAAA, 1'b1, 1'b0, 64'd15);
    stall = 1'b1;
    issue(1'b1, 1'b1, 5'd11, 2'b00, 3'b000, 32'h0000_BBBB, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_wb("stall", 5'd10, 32'h0000_AAAA, 1'b1, 1'b0, 64'd15);
    end
    // flush together with stall: instruction dropped, not counted
    flush = 1'b1;
    tick();
    chk("fl.valid", 64'(wb_valid), 64'd0);
    chk_wb("flush", 5'd0, 32'h0, 1'b0, 1'b0, 64'd15);
    flush = 1'b0; stall = 1'b0;
    issue(1'b0, 1'b1, 5'd12, 2'b00, 3'b000, 32'h0000_CCCC, 32'h0);
    tick();
    chk("bub.valid", 64'(wb_valid), 64'd0);
    chk_wb("bubble", 5'd0, 32'h0, 1'b0, 1'b0, 64'd15);

    // reset mid-operation discards WB and clears the counter
    issue(1'b1, 1'b1, 5'd13, 2'b00, 3'b000, 32'h0000_DDDD, 32'h0);
    tick(); chk_wb("prerst", 5'd13, 32'h0000_DDDD, 1'b1, 1'b0, 64'd15);
    rst = 1'b1;
    tick();
    chk("mrst.valid", 64'(wb_valid), 64'd0);
    chk_wb("midrst", 5'd0, 32'h0, 1'b0, 1'b0, 64'd0);
    rst = 1'b0;

    // counter wrap
    issue(1'b1, 1'b1, 5'd14, 2'b00, 3'b000, 32'h0000_EEEE, 32'h0);
    tick();
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    chk("wrap.pre", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0);
    tick();
    chk("wrap.post", instret, 64'd0);
    tick();
    chk("wrap.hold", instret, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
